// File: rtl/junction_pkg.sv
// Shared types and helpers for the junction scheduler: lamp codes, FSM states,
// requester indices and the round-robin pick.
package junction_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

  typedef enum logic [2:0] {
    S_ALL_RED,
    S_YEL_IN,
    S_GREEN,
    S_YEL_OUT,
    S_WALK
  } sched_state_t;

  localparam int REQ_EW  = 0;
  localparam int REQ_NS  = 1;
  localparam int REQ_PED = 2;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // One-hot winner: first set bit of pend, scanning from ptr in EW->NS->PED order.
  function automatic logic [2:0] rr_pick(input logic [2:0] pend, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [2:0] win;
    win = '0;
    idx = ptr;
    for (int k = 0; k < 3; k++) begin
      if (win == '0 && pend[idx]) win[idx] = 1'b1;
      idx = rr_next(idx);
    end
    return win;
  endfunction

endpackage

// File: rtl/junction_scheduler_if.sv
// Request/lamp bundle between the junction scheduler and its environment.
interface junction_scheduler_if;
  import junction_pkg::*;

  logic       req_ew;
  logic       req_ns;
  logic       req_ped;
  logic       emerg;
  light_t     ew_light;
  light_t     ns_light;
  logic       walk;
  logic [2:0] grant;
  logic       busy;

  modport master (
    output req_ew, req_ns, req_ped, emerg,
    input  ew_light, ns_light, walk, grant, busy
  );

  modport slave (
    input  req_ew, req_ns, req_ped, emerg,
    output ew_light, ns_light, walk, grant, busy
  );
endinterface

// File: rtl/junction_scheduler_phase_timer.sv
// Loadable down-counter that times every scheduler phase; holds at zero.
module phase_timer #(
  parameter int unsigned     CW      = 6,
  parameter logic [CW-1:0]   RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (!rstb)                      count <= RST_VAL;
    else if (load)                  count <= load_val;
    else if (dec && count != '0)    count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/junction_scheduler.sv
// Round-robin junction scheduler: grants EW, NS or pedestrians in turn and
// sequences each grant through timed lamp phases.
//   state     | meaning
//   S_ALL_RED | clearance / idle, arbitration once timer hits 0
//   S_YEL_IN  | granted car direction shows yellow before green
//   S_GREEN   | granted car direction green, may re-extend
//   S_YEL_OUT | granted car direction yellow before all-red
//   S_WALK    | pedestrian walk, both directions red
module junction_scheduler
  import junction_pkg::*;
#(
  parameter int unsigned CW       = 6,
  parameter int unsigned T_ALLRED = 2,
  parameter int unsigned T_YEL    = 2,
  parameter int unsigned T_GREEN  = 4,
  parameter int unsigned T_WALK   = 3,
  parameter int unsigned MAX_EXT  = 2
) (
  input logic                 clk,
  input logic                 rstb,
  junction_scheduler_if.slave bus
);

  localparam logic [CW-1:0] LD_ALLRED = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] LD_YEL    = CW'(T_YEL - 1);
  localparam logic [CW-1:0] LD_GREEN  = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] LD_WALK   = CW'(T_WALK - 1);

  sched_state_t  state_q, state_d;
  logic [2:0]    pending_q, pending_d;
  logic [2:0]    grant_q, grant_d;
  logic [1:0]    rr_q, rr_d;
  logic [3:0]    ext_q, ext_d;
  logic [2:0]    req_v, win;
  logic          tmr_load, tmr_dec, tmr_zero;
  logic [CW-1:0] tmr_val, tmr_count;
  light_t        ew_q, ns_q, ew_d, ns_d, lt_d;
  logic          walk_q, busy_q;

  phase_timer #(.CW(CW), .RST_VAL(LD_ALLRED)) u_timer (
    .clk      (clk),
    .rstb     (rstb),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  assign req_v   = {bus.req_ped, bus.req_ns, bus.req_ew};
  assign win     = rr_pick(pending_q, rr_q);
  assign tmr_dec = !tmr_load && (tmr_count != '0);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    ext_d     = ext_q;
    tmr_load  = 1'b0;
    tmr_val   = LD_ALLRED;
    pending_d = pending_q | (req_v & ~grant_q);

    unique case (state_q)
      S_ALL_RED: begin
        if (tmr_zero && !bus.emerg && win != '0) begin
          grant_d   = win;
          pending_d = pending_d & ~win;
          tmr_load  = 1'b1;
          if (win[REQ_EW])      rr_d = 2'd1;
          else if (win[REQ_NS]) rr_d = 2'd2;
          else                  rr_d = 2'd0;
          if (win[REQ_PED]) begin
            state_d = S_WALK;
            tmr_val = LD_WALK;
          end else begin
            state_d = S_YEL_IN;
            tmr_val = LD_YEL;
            ext_d   = '0;
          end
        end
      end
      S_YEL_IN: begin
        if (bus.emerg) begin
          state_d  = S_YEL_OUT;
          tmr_load = 1'b1;
          tmr_val  = LD_YEL;
        end else if (tmr_zero) begin
          state_d  = S_GREEN;
          tmr_load = 1'b1;
          tmr_val  = LD_GREEN;
        end
      end
      S_GREEN: begin
        if (bus.emerg) begin
          state_d  = S_YEL_OUT;
          tmr_load = 1'b1;
          tmr_val  = LD_YEL;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          // Extend only while the served side still asks and nobody else waits.
          if ((req_v & grant_q) != '0 && (pending_q & ~grant_q) == '0 &&
              ext_q < 4'(MAX_EXT)) begin
            tmr_val = LD_GREEN;
            ext_d   = ext_q + 4'd1;
          end else begin
            state_d = S_YEL_OUT;
            tmr_val = LD_YEL;
          end
        end
      end
      S_YEL_OUT, S_WALK: begin
        if (tmr_zero) begin
          state_d  = S_ALL_RED;
          grant_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = LD_ALLRED;
        end
      end
      default: begin
        state_d  = S_ALL_RED;
        grant_d  = '0;
        tmr_load = 1'b1;
        tmr_val  = LD_ALLRED;
      end
    endcase

    unique case (state_d)
      S_YEL_IN, S_YEL_OUT: lt_d = YELLOW;
      S_GREEN:             lt_d = GREEN;
      default:             lt_d = RED;
    endcase
    ew_d = grant_d[REQ_EW] ? lt_d : RED;
    ns_d = grant_d[REQ_NS] ? lt_d : RED;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q   <= S_ALL_RED;
      pending_q <= '0;
      grant_q   <= '0;
      rr_q      <= 2'd0;
      ext_q     <= '0;
      ew_q      <= RED;
      ns_q      <= RED;
      walk_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      ext_q     <= ext_d;
      ew_q      <= ew_d;
      ns_q      <= ns_d;
      walk_q    <= (state_d == S_WALK);
      busy_q    <= (state_d != S_ALL_RED);
    end
  end

  assign bus.ew_light = ew_q;
  assign bus.ns_light = ns_q;
  assign bus.walk     = walk_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = busy_q;

endmodule
